// File: rtl/cd_rx_pkg.sv
// Shared definitions for the receive-frame assembler: FSM encoding, error causes,
// header byte positions and counter widths.
package cd_rx_pkg;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } rx_state_t;

  localparam logic [1:0] ERR_NONE       = 2'd0;
  localparam logic [1:0] ERR_CRC        = 2'd1;
  localparam logic [1:0] ERR_INCOMPLETE = 2'd2;
  localparam logic [1:0] ERR_OVERFLOW   = 2'd3;

  localparam int BYTE_CNT_W = 9;
  localparam int STAT_W     = 16;

  localparam logic [BYTE_CNT_W-1:0] IDX_SRC = 9'd0;
  localparam logic [BYTE_CNT_W-1:0] IDX_DST = 9'd1;
  localparam logic [BYTE_CNT_W-1:0] IDX_LEN = 9'd2;

endpackage

// File: rtl/cd_rx_stats.sv
// Saturating frame statistics (good hand-overs, error pulses, filtered frames).
// Clear has priority over any increment arriving in the same cycle.
module cd_rx_stats
  import cd_rx_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              inc_ok,
  input  logic              inc_err,
  input  logic              inc_drop,
  output logic [STAT_W-1:0] cnt_ok,
  output logic [STAT_W-1:0] cnt_err,
  output logic [STAT_W-1:0] cnt_drop
);

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v, input logic inc);
    return (inc && (v != '1)) ? v + 1'b1 : v;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_ok   <= '0;
      cnt_err  <= '0;
      cnt_drop <= '0;
    end else if (clr) begin
      cnt_ok   <= '0;
      cnt_err  <= '0;
      cnt_drop <= '0;
    end else begin
      cnt_ok   <= sat_inc(cnt_ok, inc_ok);
      cnt_err  <= sat_inc(cnt_err, inc_err);
      cnt_drop <= sat_inc(cnt_drop, inc_drop);
    end
  end

endmodule

// File: rtl/cd_rx_frame.sv
// Receive-frame assembler: address filtering, CRC/length validation, RAM writes and
// buffer hand-over. Define CD_RX_STATS_EN to build the saturating statistics counters.
module cd_rx_frame
  import cd_rx_pkg::*;
#(
  parameter int A_W  = 8,
  parameter int MC_N = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        filter,
  input  logic [8*MC_N-1:0] filter_mc,
  input  logic [MC_N-1:0]   mc_en,
  input  logic              user_crc,
  input  logic              not_drop,
  input  logic              abort,
  output logic              error,
  output logic [1:0]        err_code,
  input  logic              des_bus_idle,
  input  logic [7:0]        des_data,
  input  logic [15:0]       des_crc_data,
  input  logic              des_data_clk,
  output logic              des_force_wait_idle,
  output logic [7:0]        ram_wr_byte,
  output logic [A_W-1:0]    ram_wr_addr,
  output logic              ram_wr_en,
  output logic [A_W-1:0]    ram_wr_flags,
  output logic              ram_switch,
  input  logic              stats_clr,
  output logic [15:0]       cnt_ok,
  output logic [15:0]       cnt_err,
  output logic [15:0]       cnt_drop
);

  localparam int                    DEPTH_I = 1 << A_W;
  localparam logic [BYTE_CNT_W:0]   DEPTH   = DEPTH_I[BYTE_CNT_W:0];

  rx_state_t             state;
  logic [BYTE_CNT_W-1:0] byte_cnt;
  logic [7:0]            len;
  logic                  drop;
  logic                  overflow;

  logic mc_hit;
  logic promisc;
  logic fits;
  logic last_byte;
  logic idle_end;

  // Received length clipped to what the flags field can carry.
  function automatic logic [A_W-1:0] sat_len(input logic [BYTE_CNT_W:0] n);
    return (n >= DEPTH) ? '1 : n[A_W-1:0];
  endfunction

  function automatic logic [BYTE_CNT_W-1:0] sat_cnt(input logic [BYTE_CNT_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  always_comb begin
    mc_hit = 1'b0;
    for (int k = 0; k < MC_N; k++) begin
      if (mc_en[k] && (filter_mc[8*k +: 8] == des_data)) mc_hit = 1'b1;
    end
  end

  assign promisc   = (filter == 8'hff);
  assign fits      = ({1'b0, byte_cnt} < DEPTH);
  assign last_byte = (state == RECV) && des_data_clk && (byte_cnt == ({1'b0, len} + 9'd4));
  assign idle_end  = (state == RECV) && !des_data_clk && des_bus_idle && (byte_cnt >= 9'd2);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state               <= INIT;
      byte_cnt            <= '0;
      len                 <= '0;
      drop                <= 1'b0;
      overflow            <= 1'b0;
      error               <= 1'b0;
      err_code            <= ERR_NONE;
      des_force_wait_idle <= 1'b0;
      ram_wr_byte         <= '0;
      ram_wr_addr         <= '0;
      ram_wr_en           <= 1'b0;
      ram_wr_flags        <= '0;
      ram_switch          <= 1'b0;
    end else begin
      error               <= 1'b0;
      des_force_wait_idle <= 1'b0;
      ram_wr_en           <= 1'b0;
      ram_switch          <= 1'b0;

      if (abort) begin
        state <= INIT;
      end else begin
        case (state)
          INIT: begin
            byte_cnt            <= '0;
            len                 <= '0;
            drop                <= 1'b0;
            overflow            <= 1'b0;
            des_force_wait_idle <= !des_bus_idle;
            state               <= RECV;
          end

          RECV: begin
            if (des_data_clk) begin
              byte_cnt <= sat_cnt(byte_cnt);
              if (fits) begin
                ram_wr_byte <= des_data;
                ram_wr_addr <= byte_cnt[A_W-1:0];
                ram_wr_en   <= 1'b1;
              end else begin
                overflow <= 1'b1;
              end

              if (!promisc) begin
                if ((byte_cnt == IDX_SRC) && (des_data == filter)) drop <= 1'b1;
                if ((byte_cnt == IDX_DST) && (des_data != filter) && (des_data != 8'hff) && !mc_hit)
                  drop <= 1'b1;
              end
              if (byte_cnt == IDX_LEN) len <= des_data;

              // The current strobe may itself be the first one past the buffer end.
              if (last_byte) begin
                state <= DONE;
                if (!drop) begin
                  if (overflow || !fits) begin
                    error    <= 1'b1;
                    err_code <= ERR_OVERFLOW;
                    if (not_drop) begin
                      ram_wr_flags <= '1;
                      ram_switch   <= 1'b1;
                    end
                  end else if ((des_crc_data != 16'h0) && !user_crc) begin
                    error    <= 1'b1;
                    err_code <= ERR_CRC;
                    if (not_drop) begin
                      ram_wr_flags <= sat_len({1'b0, byte_cnt} + 10'd1);
                      ram_switch   <= 1'b1;
                    end
                  end else begin
                    ram_wr_flags <= '0;
                    ram_switch   <= 1'b1;
                  end
                end
              end
            end else if (des_bus_idle && (byte_cnt == 9'd1)) begin
              state <= DONE;
            end else if (idle_end) begin
              state <= DONE;
              if (!drop) begin
                error    <= 1'b1;
                err_code <= ERR_INCOMPLETE;
                if (not_drop) begin
                  ram_wr_flags <= sat_len({1'b0, byte_cnt});
                  ram_switch   <= 1'b1;
                end
              end
            end
          end

          default: state <= INIT;
        endcase
      end
    end
  end

`ifdef CD_RX_STATS_EN
  logic drop_end;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) drop_end <= 1'b0;
    else          drop_end <= !abort && drop && (last_byte || idle_end);
  end

  // Errored hand-overs always coincide with an error pulse, so ok excludes them.
  cd_rx_stats u_stats (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (stats_clr),
    .inc_ok   (ram_switch && !error),
    .inc_err  (error),
    .inc_drop (drop_end),
    .cnt_ok   (cnt_ok),
    .cnt_err  (cnt_err),
    .cnt_drop (cnt_drop)
  );
`else
  logic unused_stats_clr;

  assign unused_stats_clr = stats_clr;
  assign cnt_ok           = '0;
  assign cnt_err          = '0;
  assign cnt_drop         = '0;
`endif

endmodule

// File: tb/tb_cd_rx_frame.sv
// Bench for cd_rx_frame: two instances (A_W=8 and A_W=6) share stimulus; writes,
// hand-overs and errors are checked against scoreboard queues filled by a reference model.
module tb_cd_rx_frame;

`ifdef CD_RX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic [7:0]  filter;
  logic [15:0] filter_mc;
  logic [1:0]  mc_en;
  logic        user_crc, not_drop, abort;
  logic        des_bus_idle, des_data_clk, stats_clr;
  logic [7:0]  des_data;
  logic [15:0] des_crc_data;

  logic        err_a, err_b, force_a, force_b, we_a, we_b, sw_a, sw_b;
  logic [1:0]  code_a, code_b;
  logic [7:0]  wb_a, wb_b, wa_a, fl_a;
  logic [5:0]  wa_b, fl_b;
  logic [15:0] ok_a, er_a, dr_a, ok_b, er_b, dr_b;

  int checks = 0;
  int errors = 0;
  int wq_a[$], wq_b[$], sq_a[$], sq_b[$], eq_a[$], eq_b[$];
  int exp_ok[2], exp_err[2], exp_drop[2];
  int force_seen_a = 0, force_seen_b = 0, force_exp = 0;
  int mon_a, mon_b;
  longint t_strobe, t_sw_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cd_rx_frame #(.A_W(8), .MC_N(2)) dut (
    .clk(clk), .reset_n(reset_n), .filter(filter), .filter_mc(filter_mc), .mc_en(mc_en),
    .user_crc(user_crc), .not_drop(not_drop), .abort(abort), .error(err_a), .err_code(code_a),
    .des_bus_idle(des_bus_idle), .des_data(des_data), .des_crc_data(des_crc_data),
    .des_data_clk(des_data_clk), .des_force_wait_idle(force_a), .ram_wr_byte(wb_a),
    .ram_wr_addr(wa_a), .ram_wr_en(we_a), .ram_wr_flags(fl_a), .ram_switch(sw_a),
    .stats_clr(stats_clr), .cnt_ok(ok_a), .cnt_err(er_a), .cnt_drop(dr_a)
  );

  cd_rx_frame #(.A_W(6), .MC_N(2)) dut6 (
    .clk(clk), .reset_n(reset_n), .filter(filter), .filter_mc(filter_mc), .mc_en(mc_en),
    .user_crc(user_crc), .not_drop(not_drop), .abort(abort), .error(err_b), .err_code(code_b),
    .des_bus_idle(des_bus_idle), .des_data(des_data), .des_crc_data(des_crc_data),
    .des_data_clk(des_data_clk), .des_force_wait_idle(force_b), .ram_wr_byte(wb_b),
    .ram_wr_addr(wa_b), .ram_wr_en(we_b), .ram_wr_flags(fl_b), .ram_switch(sw_b),
    .stats_clr(stats_clr), .cnt_ok(ok_b), .cnt_err(er_b), .cnt_drop(dr_b)
  );

  // Scoreboard consumers, instance A (A_W=8)
  always @(negedge clk) begin
    if (reset_n) begin
      if (force_a) force_seen_a++;
      if (we_a) begin
        checks++;
        if (wq_a.size() == 0) begin
          errors++;
          $display("FAIL wr_a: unexpected write addr=%0d data=%02h, none expected", wa_a, wb_a);
        end else begin
          mon_a = wq_a.pop_front();
          if ((int'(wa_a) * 256 + int'(wb_a)) !== mon_a) begin
            errors++;
            $display("FAIL wr_a: got addr=%0d data=%02h, want addr=%0d data=%02h",
                     wa_a, wb_a, mon_a / 256, mon_a % 256);
          end
        end
      end
      if (sw_a) begin
        t_sw_a = $time;
        checks++;
        if (sq_a.size() == 0) begin
          errors++;
          $display("FAIL switch_a: unexpected ram_switch flags=%0d", fl_a);
        end else begin
          mon_a = sq_a.pop_front();
          if (int'(fl_a) !== mon_a) begin
            errors++;
            $display("FAIL flags_a: got %0d, want %0d", fl_a, mon_a);
          end
        end
      end
      if (err_a) begin
        checks++;
        if (eq_a.size() == 0) begin
          errors++;
          $display("FAIL error_a: unexpected error pulse code=%0d", code_a);
        end else begin
          mon_a = eq_a.pop_front();
          if (int'(code_a) !== mon_a) begin
            errors++;
            $display("FAIL err_code_a: got %0d, want %0d", code_a, mon_a);
          end
        end
      end
    end
  end

  // Scoreboard consumers, instance B (A_W=6)
  always @(negedge clk) begin
    if (reset_n) begin
      if (force_b) force_seen_b++;
      if (we_b) begin
        checks++;
        if (wq_b.size() == 0) begin
          errors++;
          $display("FAIL wr_b: unexpected write addr=%0d data=%02h, none expected", wa_b, wb_b);
        end else begin
          mon_b = wq_b.pop_front();
          if ((int'(wa_b) * 256 + int'(wb_b)) !== mon_b) begin
            errors++;
            $display("FAIL wr_b: got addr=%0d data=%02h, want addr=%0d data=%02h",
                     wa_b, wb_b, mon_b / 256, mon_b % 256);
          end
        end
      end
      if (sw_b) begin
        checks++;
        if (sq_b.size() == 0) begin
          errors++;
          $display("FAIL switch_b: unexpected ram_switch flags=%0d", fl_b);
        end else begin
          mon_b = sq_b.pop_front();
          if (int'(fl_b) !== mon_b) begin
            errors++;
            $display("FAIL flags_b: got %0d, want %0d", fl_b, mon_b);
          end
        end
      end
      if (err_b) begin
        checks++;
        if (eq_b.size() == 0) begin
          errors++;
          $display("FAIL error_b: unexpected error pulse code=%0d", code_b);
        end else begin
          mon_b = eq_b.pop_front();
          if (int'(code_b) !== mon_b) begin
            errors++;
            $display("FAIL err_code_b: got %0d, want %0d", code_b, mon_b);
          end
        end
      end
    end
  end

  task automatic push_w(input int k, input int v);
    if (k == 0) wq_a.push_back(v); else wq_b.push_back(v);
  endtask

  task automatic push_s(input int k, input int v);
    if (k == 0) sq_a.push_back(v); else sq_b.push_back(v);
  endtask

  task automatic push_e(input int k, input int v);
    exp_err[k]++;
    if (k == 0) eq_a.push_back(v); else eq_b.push_back(v);
  endtask

  // Reference model: expected writes, hand-overs, errors and counter moves for one frame.
  task automatic model_frame(input int k, input logic [7:0] fb[$], input int n_send,
                             input bit crc_bad, input bit abort_last);
    int  depth;
    bit  drop, hit, complete;
    depth    = (k == 0) ? 256 : 64;
    complete = (n_send == fb.size());
    for (int i = 0; i < n_send; i++)
      if (i < depth && !(abort_last && i == n_send - 1)) push_w(k, i * 256 + int'(fb[i]));
    hit  = (n_send >= 2) && ((mc_en[0] && filter_mc[7:0] == fb[1]) ||
                             (mc_en[1] && filter_mc[15:8] == fb[1]));
    drop = (filter != 8'hff) && ((n_send >= 1 && fb[0] == filter) ||
           (n_send >= 2 && fb[1] != filter && fb[1] != 8'hff && !hit));
    if (abort_last) begin
    end else if (complete) begin
      if (drop) exp_drop[k]++;
      else if (n_send > depth) begin
        push_e(k, 3);
        if (not_drop) push_s(k, depth - 1);
      end else if (crc_bad && !user_crc) begin
        push_e(k, 1);
        if (not_drop) push_s(k, (n_send > depth - 1) ? depth - 1 : n_send);
      end else begin
        push_s(k, 0);
        exp_ok[k]++;
      end
    end else if (n_send >= 2) begin
      if (drop) exp_drop[k]++;
      else begin
        push_e(k, 2);
        if (not_drop) push_s(k, (n_send > depth - 1) ? depth - 1 : n_send);
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] fb[$], input int n_send, input bit crc_bad,
                            input bit abort_last, input bit clr_end);
    bit complete;
    complete = (n_send == fb.size());
    model_frame(0, fb, n_send, crc_bad, abort_last);
    model_frame(1, fb, n_send, crc_bad, abort_last);
    for (int i = 0; i < n_send; i++) begin
      @(posedge clk); #1;
      des_bus_idle = 1'b0;
      des_data     = fb[i];
      des_data_clk = 1'b1;
      des_crc_data = (complete && i == n_send - 1) ? (crc_bad ? 16'h5a5a : 16'h0000) : 16'hbeef;
      abort        = abort_last && (i == n_send - 1);
      @(posedge clk);
      t_strobe = $time;
      #1;
      des_data_clk = 1'b0;
      abort        = 1'b0;
      des_crc_data = 16'hbeef;
    end
    des_bus_idle = 1'b1;
    if (clr_end) begin
      stats_clr = 1'b1;
      for (int k = 0; k < 2; k++) begin
        exp_ok[k] = 0; exp_err[k] = 0; exp_drop[k] = 0;
      end
      @(posedge clk); #1;
      stats_clr = 1'b0;
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; filter = 8'h05; filter_mc = 16'h0; mc_en = 2'b00;
    user_crc = 1'b0; not_drop = 1'b1; abort = 1'b0; des_bus_idle = 1'b1;
    des_data_clk = 1'b0; des_data = 8'h0; des_crc_data = 16'h0; stats_clr = 1'b0;
    for (int k = 0; k < 2; k++) begin
      exp_ok[k] = 0; exp_err[k] = 0; exp_drop[k] = 0;
    end
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if ({err_a, code_a, force_a, we_a, sw_a, wa_a, wb_a, fl_a} !== 30'h0) begin
      errors++;
      $display("FAIL reset_outputs_a: got %h, want 0", {err_a, code_a, force_a, we_a, sw_a, wa_a, wb_a, fl_a});
    end
    checks++;
    if ({ok_a, er_a, dr_a} !== 48'h0) begin
      errors++;
      $display("FAIL reset_counters_a: got %h, want 0", {ok_a, er_a, dr_a});
    end
    checks++;
    if ({err_b, code_b, force_b, we_b, sw_b, wa_b, wb_b, fl_b} !== 26'h0) begin
      errors++;
      $display("FAIL reset_outputs_b: got %h, want 0", {err_b, code_b, force_b, we_b, sw_b, wa_b, wb_b, fl_b});
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_basic;
    filter = 8'h05; mc_en = 2'b00; not_drop = 1'b1; user_crc = 1'b0;
    send_frame('{8'h01, 8'h05, 8'h02, 8'haa, 8'hbb, 8'hc0, 8'hc1}, 7, 1'b0, 1'b0, 1'b0);
    checks++;
    if (t_sw_a != t_strobe + 5) begin
      errors++;
      $display("FAIL switch_latency: switch seen at %0d, want %0d", t_sw_a, t_strobe + 5);
    end
    checks++;
    if (ok_a !== (STATS ? 16'(exp_ok[0]) : 16'h0)) begin
      errors++;
      $display("FAIL basic_cnt_ok: got %0d, want %0d", ok_a, STATS ? exp_ok[0] : 0);
    end
    checks++;
    if (wq_a.size() + sq_a.size() + eq_a.size() + wq_b.size() + sq_b.size() + eq_b.size() != 0) begin
      errors++;
      $display("FAIL basic_drain: %0d expected events never produced, want 0",
               wq_a.size() + sq_a.size() + eq_a.size() + wq_b.size() + sq_b.size() + eq_b.size());
    end
  endtask

  task automatic test_multicast;
    filter = 8'h05; filter_mc = 16'h2033; mc_en = 2'b10;
    send_frame('{8'h01, 8'h20, 8'h01, 8'h77, 8'hc0, 8'hc1}, 6, 1'b0, 1'b0, 1'b0);
    mc_en = 2'b00;
    send_frame('{8'h01, 8'h20, 8'h01, 8'h77, 8'hc0, 8'hc1}, 6, 1'b0, 1'b0, 1'b0);
    send_frame('{8'h02, 8'hff, 8'h00, 8'hc0, 8'hc1}, 5, 1'b0, 1'b0, 1'b0);
    send_frame('{8'h05, 8'hff, 8'h00, 8'hc0, 8'hc1}, 5, 1'b0, 1'b0, 1'b0);
    filter = 8'hff;
    send_frame('{8'hff, 8'h99, 8'h01, 8'h12, 8'hc0, 8'hc1}, 6, 1'b0, 1'b0, 1'b0);
    filter = 8'h05;
    checks++;
    if (dr_a !== (STATS ? 16'(exp_drop[0]) : 16'h0)) begin
      errors++;
      $display("FAIL mc_cnt_drop: got %0d, want %0d", dr_a, STATS ? exp_drop[0] : 0);
    end
    checks++;
    if (ok_a !== (STATS ? 16'(exp_ok[0]) : 16'h0)) begin
      errors++;
      $display("FAIL mc_cnt_ok: got %0d, want %0d", ok_a, STATS ? exp_ok[0] : 0);
    end
    checks++;
    if (sq_a.size() + wq_a.size() + sq_b.size() != 0) begin
      errors++;
      $display("FAIL mc_drain: %0d expected events never produced, want 0",
               sq_a.size() + wq_a.size() + sq_b.size());
    end
  endtask

  task automatic test_crc;
    not_drop = 1'b1;
    send_frame('{8'h01, 8'h05, 8'h02, 8'haa, 8'hbb, 8'hc0, 8'hc1}, 7, 1'b1, 1'b0, 1'b0);
    not_drop = 1'b0;
    send_frame('{8'h01, 8'h05, 8'h02, 8'haa, 8'hbb, 8'hc0, 8'hc1}, 7, 1'b1, 1'b0, 1'b0);
    not_drop = 1'b1; user_crc = 1'b1;
    send_frame('{8'h01, 8'h05, 8'h01, 8'h3c, 8'hc0, 8'hc1}, 6, 1'b1, 1'b0, 1'b0);
    user_crc = 1'b0;
    checks++;
    if (code_a !== 2'd1) begin
      errors++;
      $display("FAIL crc_code_held: got %0d, want 1", code_a);
    end
    checks++;
    if (er_a !== (STATS ? 16'(exp_err[0]) : 16'h0)) begin
      errors++;
      $display("FAIL crc_cnt_err: got %0d, want %0d", er_a, STATS ? exp_err[0] : 0);
    end
    checks++;
    if (sq_a.size() + eq_a.size() + eq_b.size() != 0) begin
      errors++;
      $display("FAIL crc_drain: %0d expected events never produced, want 0",
               sq_a.size() + eq_a.size() + eq_b.size());
    end
  endtask

  task automatic test_incomplete;
    not_drop = 1'b1;
    send_frame('{8'h01, 8'h05, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'hc0, 8'hc1}, 3, 1'b0, 1'b0, 1'b0);
    send_frame('{8'h01, 8'h05, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'hc0, 8'hc1}, 1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (code_a !== 2'd2) begin
      errors++;
      $display("FAIL incomplete_code: got %0d, want 2", code_a);
    end
    checks++;
    if (sq_a.size() + eq_a.size() + wq_a.size() != 0) begin
      errors++;
      $display("FAIL incomplete_drain: %0d expected events never produced, want 0",
               sq_a.size() + eq_a.size() + wq_a.size());
    end
  endtask

  task automatic test_overflow;
    logic [7:0] fb[$];
    fb = {};
    fb.push_back(8'h01); fb.push_back(8'h05); fb.push_back(8'd100);
    for (int i = 0; i < 100; i++) fb.push_back(8'(i * 7 + 3));
    fb.push_back(8'hc0); fb.push_back(8'hc1);
    not_drop = 1'b1;
    send_frame(fb, fb.size(), 1'b0, 1'b0, 1'b0);
    checks++;
    if (code_b !== 2'd3) begin
      errors++;
      $display("FAIL overflow_code_b: got %0d, want 3", code_b);
    end
    checks++;
    if (fl_b !== 6'h3f) begin
      errors++;
      $display("FAIL overflow_flags_b: got %h, want 3f", fl_b);
    end
    checks++;
    if (wq_b.size() + sq_b.size() + eq_b.size() + sq_a.size() != 0) begin
      errors++;
      $display("FAIL overflow_drain: %0d expected events never produced, want 0",
               wq_b.size() + sq_b.size() + eq_b.size() + sq_a.size());
    end
  endtask

  task automatic test_abort;
    send_frame('{8'h01, 8'h05, 8'h02, 8'haa, 8'hbb, 8'hc0, 8'hc1}, 7, 1'b1, 1'b1, 1'b0);
    send_frame('{8'h01, 8'h05, 8'h02, 8'haa, 8'hbb, 8'hc0, 8'hc1}, 3, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    abort = 1'b1; des_bus_idle = 1'b0;
    @(posedge clk); #1;
    abort = 1'b0;
    force_exp++;
    repeat (2) @(posedge clk);
    #1;
    des_bus_idle = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (force_seen_a !== force_exp || force_seen_b !== force_exp) begin
      errors++;
      $display("FAIL force_wait_idle: got a=%0d b=%0d pulses, want %0d", force_seen_a, force_seen_b, force_exp);
    end
    checks++;
    if (sq_a.size() + eq_a.size() + wq_a.size() != 0) begin
      errors++;
      $display("FAIL abort_drain: %0d expected events never produced, want 0",
               sq_a.size() + eq_a.size() + wq_a.size());
    end
  endtask

  task automatic test_stats_clr;
    send_frame('{8'h01, 8'h05, 8'h01, 8'h5e, 8'hc0, 8'hc1}, 6, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({ok_a, er_a, dr_a} !== 48'h0) begin
      errors++;
      $display("FAIL stats_clr_a: got ok=%0d err=%0d drop=%0d, want 0 0 0", ok_a, er_a, dr_a);
    end
    checks++;
    if ({ok_b, er_b, dr_b} !== 48'h0) begin
      errors++;
      $display("FAIL stats_clr_b: got ok=%0d err=%0d drop=%0d, want 0 0 0", ok_b, er_b, dr_b);
    end
    send_frame('{8'h01, 8'h05, 8'h01, 8'h5e, 8'hc0, 8'hc1}, 6, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ok_a !== (STATS ? 16'(exp_ok[0]) : 16'h0)) begin
      errors++;
      $display("FAIL stats_after_clr: got %0d, want %0d", ok_a, STATS ? exp_ok[0] : 0);
    end
    checks++;
    if (wq_a.size() + sq_a.size() + eq_a.size() + wq_b.size() + sq_b.size() + eq_b.size() != 0) begin
      errors++;
      $display("FAIL final_drain: %0d expected events never produced, want 0",
               wq_a.size() + sq_a.size() + eq_a.size() + wq_b.size() + sq_b.size() + eq_b.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_multicast();
    test_crc();
    test_incomplete();
    test_overflow();
    test_abort();
    test_stats_clr();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cd_rx_frame.md
# cd_rx_frame

Parametrised receive-frame assembler between the byte deserialiser and the ping-pong receive RAM. Tracks frame position, filters on source, destination, broadcast and N multicast addresses, and validates CRC. Writes accepted bytes to RAM and hands over each finished frame with a status word and an error cause. Adds buffer-depth generality, overflow detection and optional saturating statistics.

## Interface
- A_W, 8, RAM address width; legal 6..9 (9 holds a maximum 260-byte frame)
- MC_N, 2, number of multicast destination filters; legal 1..8
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- filter  in  8  own address; 8'hff = promiscuous
- filter_mc  in  8*MC_N  multicast addresses; slot k = bits [8k+7:8k]
- mc_en  in  MC_N  per-slot multicast enable
- user_crc  in  1  skip CRC check
- not_drop  in  1  hand over errored frames as well
- abort  in  1  cancel the current frame
- error  out  1  one-cycle pulse, frame in error
- err_code  out  2  0 none, 1 crc, 2 incomplete, 3 overflow; held until the next error
- des_bus_idle  in  1  bus idle from the deserialiser
- des_data  in  8  received byte
- des_crc_data  in  16  running CRC; 0 = good
- des_data_clk  in  1  byte strobe
- des_force_wait_idle  out  1  one-cycle request to resynchronise to idle
- ram_wr_byte  out  8  write data, registered
- ram_wr_addr  out  A_W  write address
- ram_wr_en  out  1  write strobe
- ram_wr_flags  out  A_W  0 = ok; otherwise received length, saturating at all-ones
- ram_switch  out  1  one-cycle buffer hand-over pulse
- stats_clr  in  1  clear statistics
- cnt_ok, cnt_err, cnt_drop  out  16 each  statistics (see Configuration)

## Operation
- Frame format: src, dst, len, len data bytes, crc_l, crc_h. Last byte index is len+4.
- byte_cnt: 9 bits. Increments on each strobe and saturates at 511.
- FSM states:
  - INIT: clear byte_cnt, len and drop. If !des_bus_idle, pulse des_force_wait_idle. Go to RECV next cycle.
  - RECV: handle strobes. Go to DONE on the last byte or on an idle terminator.
  - DONE: one cycle, then INIT.
  - abort in any state: go to INIT next cycle.
- Filtering (drop forced to 0 when filter==8'hff):
  - byte 0 == filter: drop.
  - byte 1 not equal to filter, not 8'hff, and not matching any mc_en slot: drop.
- Writes: strobe with byte_cnt < 2^A_W → register the byte, write it at address byte_cnt, set ram_wr_en. Writes occur even for dropped frames, since the buffer is not switched.
- Strobe with byte_cnt ≥ 2^A_W: no write; set the overflow flag.
- Last byte, not dropped. Priority: overflow, then CRC.
  - Overflow: error, err_code=3. If not_drop, flags = all-ones and switch.
  - CRC bad and !user_crc: error, err_code=1. If not_drop, flags = byte_cnt+1 saturated and switch.
  - Otherwise: flags=0, switch.
- des_bus_idle in RECV:
  - byte_cnt==0: no effect.
  - byte_cnt==1: silent discard, go to DONE.
  - byte_cnt≥2 and not dropped: error, err_code=2. If not_drop, flags = byte_cnt saturated and switch. Go to DONE.
- abort in the same cycle as an end event suppresses error, ram_switch and the counter update.

## Timing
- Reset: every output 0, FSM in INIT, counters 0.
- Strobe to ram_wr_en/addr/byte: 1 cycle.
- Last-byte strobe to ram_switch/error: 1 cycle. The flags are valid in the same cycle as ram_switch.
- Exactly one ram_switch per frame at most. Idle persisting beyond DONE cannot retrigger.
- The multicast compare is combinational on des_data during the strobe cycle.

## Configuration
- CD_RX_STATS_EN defined:
  - cnt_ok increments on a good hand-over.
  - cnt_err increments on every error pulse.
  - cnt_drop increments on each filtered frame at its end.
  - All saturate at 16'hffff.
  - stats_clr zeroes all three. Clear wins over a simultaneous increment.
- CD_RX_STATS_EN undefined: counters tied to 0, stats_clr ignored, no counter flops.

## Structure
- Package cd_rx_pkg: FSM state encoding (INIT, RECV, DONE), err_code constants (ERR_NONE, ERR_CRC, ERR_INCOMPLETE, ERR_OVERFLOW), the header byte indices, and the 9-bit byte_cnt width.
- Sub-module cd_rx_stats: the three saturating counters. Instantiated only under CD_RX_STATS_EN.

## Test plan
- filter=0x05, frame 01 05 02 aa bb with good CRC → writes at addresses 0..6, ram_switch with flags 0, cnt_ok=1.
- dst=0x20, filter_mc slot 1=0x20, mc_en=2'b10 → accepted. Same frame with mc_en=0 → no switch, cnt_drop=1.
- Bad CRC with not_drop=1, len=2 → error, err_code=1, flags=7, switch. With not_drop=0 → error, no switch.
- des_bus_idle after 3 bytes → error, err_code=2. A single byte followed by idle → silent discard.
- A_W=6, len=100 → no writes at index ≥ 64, err_code=3, flags 6'h3f when not_drop=1.
- abort coinciding with the last byte → no error, no switch. stats_clr together with an increment → counters 0.
